// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: flit width, direction count and the
// direction enumeration used by every router port instance.
package noc_pkg;

    localparam int NOC_FLIT_W  = 35;
    localparam int NOC_NUM_DIR = 5;

    typedef enum logic [2:0] {
        DIR_N,
        DIR_E,
        DIR_W,
        DIR_S,
        DIR_PE
    } noc_dir_e;

    typedef logic [NOC_FLIT_W-1:0] noc_flit_t;

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker. The search starts one position after
// ptr (the last winner) and wraps, so ptr itself has the lowest priority.
module noc_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    logic [IW-1:0] cand_idx;

    // Walk ptr+1 .. ptr+NREQ (mod NREQ) and latch the first active request.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        cand_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_idx = IW'((int'(ptr) + k) % NREQ);
            if (!any && req[cand_idx]) begin
                any        = 1'b1;
                gnt_idx    = cand_idx;
                gnt_onehot = NREQ'(1) << cand_idx;
            end
        end
    end

endmodule

// File: rtl/noc_out_port_sched.sv
// Output-port scheduler: round-robin arbitration of NREQ input directions
// into a DEPTH-entry output FIFO. Optional per-requester grant counters are
// built when the macro NOC_ARB_STATS_EN is defined; otherwise stat_grants
// is tied to zero and stat_clr is ignored.
module noc_out_port_sched
    import noc_pkg::*;
#(
    parameter int WIDTH = NOC_FLIT_W,
    parameter int NREQ  = 4,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           in_valid,
    input  logic [NREQ*WIDTH-1:0]     in_data,
    output logic [NREQ-1:0]           in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready,
    output logic [$clog2(NREQ)-1:0]   grant_idx,
    output logic                      busy,
    input  logic                      stat_clr,
    output logic [NREQ*16-1:0]        stat_grants
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Storage and state
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    grant_q,  grant_d;

    // Arbitration results
    logic [NREQ-1:0]  gnt_onehot;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_any;
    logic [WIDTH-1:0] in_data_a [NREQ];
    logic [WIDTH-1:0] win_data;

    logic space;
    logic push;
    logic pop;

    // Split the flat input bus into one word per requester.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign in_data_a[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    noc_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req        (in_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    assign win_data  = in_data_a[gnt_idx];
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign pop       = out_valid & out_ready;
    // A full FIFO still has room when its head leaves in the same cycle.
    assign space     = (count_q < CW'(DEPTH)) | pop;
    // While reset is held the FIFO looks empty, so mask the handshake
    // explicitly to keep in_ready low during reset.
    assign push      = rst_n & gnt_any & space;
    assign in_ready  = push ? gnt_onehot : '0;
    assign busy      = out_valid | (|in_valid);
    assign grant_idx = grant_q;

    // Next-state for pointers, occupancy and arbitration history.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            rr_ptr_d = gnt_idx;
            grant_d  = gnt_idx;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; requester 0 is first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= IW'(NREQ - 1);
            grant_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
        end
    end

    // Packet storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= win_data;
        end
    end

`ifdef NOC_ARB_STATS_EN
    // One saturating accepted-packet counter per requester.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
        logic [15:0] stat_q;

        // Clear has priority over a same-cycle increment.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stat_q <= '0;
            end else if (stat_clr) begin
                stat_q <= '0;
            end else if (push && gnt_onehot[gi] && (stat_q != 16'hFFFF)) begin
                stat_q <= stat_q + 16'd1;
            end
        end

        assign stat_grants[gi*16 +: 16] = stat_q;
    end
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr;
    assign stat_grants     = '0;
`endif

endmodule

// File: tb/tb_noc_out_port_sched.sv
// Directed bench for noc_out_port_sched: reset, rotation, backpressure,
// full-FIFO push/pop, mid-stream reset and (when NOC_ARB_STATS_EN is
// defined) the saturating grant counters.
module tb_noc_out_port_sched;

    localparam int WIDTH = 35;
    localparam int NREQ  = 4;
    localparam int DEPTH = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       in_valid;
    logic [NREQ*WIDTH-1:0] in_data;
    logic [NREQ-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic                  out_ready;
    logic [1:0]            grant_idx;
    logic                  busy;
    logic                  stat_clr;
    logic [NREQ*16-1:0]    stat_grants;

    int checks = 0;
    int errors = 0;
    int gcnt [NREQ];
    int prev;

    noc_out_port_sched #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .stat_clr    (stat_clr),
        .stat_grants (stat_grants)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packet value: requester index in the top bits, tag below.
    function automatic logic [WIDTH-1:0] pk(input int tag, input int req);
        pk = {3'(req), 32'(tag)};
    endfunction

    task automatic set_d(input int i, input logic [WIDTH-1:0] v);
        in_data[i*WIDTH +: WIDTH] = v;
    endtask

    function automatic logic [15:0] st(input int i);
        st = stat_grants[i*16 +: 16];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        stat_clr  = 1'b0;
        #2;
        rst_n = 1'b0;

        // ---------------- Reset with all requesters valid ----------------
        for (int i = 0; i < NREQ; i++) set_d(i, pk('hA0, i));
        in_valid = '1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_grant_idx", grant_idx, 0);
        chk("rst_busy", busy, 1);
        chk("rst_stats", stat_grants, 0);
        tick;
        tick;
        chk("rst_out_valid_edge", out_valid, 0);
        chk("rst_in_ready_edge", in_ready, 0);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rst_seq_ready", in_ready, 64'(1 << (k % 4)));
            tick;
            chk("rst_seq_valid", out_valid, 1);
            chk("rst_seq_data", out_data, pk('hA0, k % 4));
            chk("rst_seq_gidx", grant_idx, k % 4);
        end
        in_valid = '0;
        tick;
        chk("rst_drain", out_valid, 0);
        chk("idle_busy", busy, 0);

        // ---------------- Rotation between requesters 1 and 3 ----------------
        set_d(1, pk(1, 1));
        set_d(3, pk(3, 3));
        in_valid = 4'b1010;
        #1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            int w;
            w = (k % 2 == 0) ? 1 : 3;
            chk("rot_gidx_hold", grant_idx, prev);
            chk("rot_ready", in_ready, 64'(1 << w));
            tick;
            chk("rot_valid", out_valid, 1);
            chk("rot_data", out_data, pk(w, w));
            chk("rot_gidx", grant_idx, w);
            prev = w;
        end
        in_valid = '0;
        tick;
        chk("rot_drain", out_valid, 0);

        // ---------------- Backpressure on requester 2 ----------------
        out_ready = 1'b0;
        in_valid  = 4'b0100;
        set_d(2, pk(10, 2));
        #1;
        chk("bp_ready_a", in_ready, 4'b0100);
        tick;
        set_d(2, pk(11, 2));
        #1;
        chk("bp_ready_b", in_ready, 4'b0100);
        chk("bp_head_a", out_data, pk(10, 2));
        tick;
        set_d(2, pk(12, 2));
        #1;
        chk("bp_stall_c", in_ready, 0);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("bp_stable", out_data, pk(10, 2));
            chk("bp_stable_valid", out_valid, 1);
            chk("bp_stall_hold", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_resume_ready", in_ready, 4'b0100);
        tick;
        in_valid = '0;
        #1;
        chk("bp_head_b", out_data, pk(11, 2));
        tick;
        chk("bp_head_c", out_data, pk(12, 2));
        chk("bp_valid_c", out_valid, 1);
        tick;
        chk("bp_empty", out_valid, 0);
        chk("bp_busy", busy, 0);

        // ---------------- Full FIFO with simultaneous push and pop ----------------
        out_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_d(i, pk('h40, i));
        in_valid = '1;
        #1;
        chk("full_fill0", in_ready, 4'b1000);
        tick;
        chk("full_fill1", in_ready, 4'b0001);
        tick;
        chk("full_stall", in_ready, 0);
        chk("full_head", out_data, pk('h40, 3));
        for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("full_valid", out_valid, 1);
            chk("full_order", out_data, pk('h40, (k + 3) % 4));
            chk("full_ready", in_ready, 64'(1 << ((k + 1) % 4)));
            for (int i = 0; i < NREQ; i++) begin
                if (in_valid[i] && in_ready[i]) gcnt[i]++;
            end
            tick;
        end
        for (int i = 0; i < NREQ; i++) chk("full_gcnt", gcnt[i], 2);
        out_ready = 1'b0;
        #1;
        chk("full_count2", in_ready, 0);
        chk("full_head_after", out_data, pk('h40, 3));

        // ---------------- Reset mid-stream ----------------
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_in_ready", in_ready, 0);
        chk("mid_stats", stat_grants, 0);
        tick;
        rst_n     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("mid_no_old", out_valid, 0);
        end
        set_d(0, pk('h50, 0));
        in_valid = 4'b0001;
        #1;
        chk("mid_ready0", in_ready, 4'b0001);
        tick;
        in_valid = '0;
        #1;
        chk("mid_new_valid", out_valid, 1);
        chk("mid_new_data", out_data, pk('h50, 0));
`ifdef NOC_ARB_STATS_EN
        chk("mid_stat0", st(0), 1);
`else
        chk("mid_stat0", st(0), 0);
`endif
        tick;
        chk("mid_empty", out_valid, 0);

        // ---------------- Statistics ----------------
`ifdef NOC_ARB_STATS_EN
        stat_clr = 1'b1;
        tick;
        stat_clr = 1'b0;
        chk("stat_clr0", st(0), 0);
        in_valid = 4'b0001;
        set_d(0, pk('h60, 0));
        for (int k = 0; k < 3; k++) tick;
        chk("stat_three", st(0), 3);
        stat_clr = 1'b1;
        chk("stat_pending", in_ready, 4'b0001);
        tick;
        stat_clr = 1'b0;
        chk("stat_clr_wins", st(0), 0);
        tick;
        chk("stat_after_clr", st(0), 1);
        for (int k = 0; k < 70000; k++) tick;
        chk("stat_saturate", st(0), 16'hFFFF);
        chk("stat_other1", st(1), 0);
        chk("stat_other3", st(3), 0);
        in_valid = '0;
`else
        stat_clr = 1'b1;
        in_valid = 4'b0001;
        tick;
        tick;
        chk("stat_off_zero", stat_grants, 0);
        stat_clr = 1'b0;
        tick;
        chk("stat_off_zero2", stat_grants, 0);
        in_valid = '0;
`endif
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_out_port_sched.md
# noc_out_port_sched

Clocked output-port scheduler for the 5-port mesh router. It shares one router output direction between the four competing input directions, using round-robin arbitration over 35-bit packets. Granted packets go into a small output FIFO that decouples the arbitration from downstream backpressure. One instance sits in front of each of the N/E/W/S/PE outputs.

## Interface
- `WIDTH`, 35, packet width in bits.
- `NREQ`, 4, number of requesters (input directions competing for this output).
- `DEPTH`, 2, output FIFO depth in packets (power of 2, ≥2).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  NREQ  requester i holds a packet.
- `in_data`  in  NREQ×WIDTH  packet of requester i.
- `in_ready`  out  NREQ  one-hot or zero; requester i's packet is accepted this cycle.
- `out_valid`  out  1  FIFO head is valid.
- `out_data`  out  WIDTH  FIFO head packet.
- `out_ready`  in  1  downstream accepts the head this cycle.
- `grant_idx`  out  $clog2(NREQ)  index of the last requester accepted (registered).
- `busy`  out  1  FIFO non-empty, or any `in_valid` high.
- `stat_clr`  in  1  clears the statistics counters (see Configuration).
- `stat_grants`  out  NREQ×16  per-requester accepted-packet counts.

## Operation
- **Transfers.** An input transfer happens when `in_valid[i] & in_ready[i]`. An output transfer happens when `out_valid & out_ready`.
- **Space.** `space = (count < DEPTH) | (out_valid & out_ready)`. This allows same-cycle push and pop when the FIFO is full.
- **Arbitration.** `rr_ptr` holds the last granted index.
  - Search order is `rr_ptr+1, rr_ptr+2, …, rr_ptr` (mod NREQ).
  - The first requester in that order with `in_valid` high is the winner.
  - `in_ready[winner] = space`. All other `in_ready` bits are 0.
  - `in_ready` may depend combinationally on `in_valid` and `out_ready`. Requesters must not make `in_valid` depend on `in_ready`.
- **On an input transfer:**
  - push `in_data[winner]`;
  - `rr_ptr <= winner`;
  - `grant_idx <= winner`.
- **No transfer.** With no input transfer, `rr_ptr` and `grant_idx` hold. A requester that does not win keeps its packet; this block never drops packets.
- **FIFO.** Circular buffer with `wr_ptr`, `rd_ptr` and `count` (0..DEPTH).
  - `out_valid = (count != 0)`.
  - `out_data = mem[rd_ptr]`.
  - Pointers wrap modulo DEPTH.
- **Simultaneous push and pop.** `count` is unchanged; both pointers advance.
- **Empty FIFO.** A push into an empty FIFO is visible on `out_valid` next cycle; there is no same-cycle bypass.
- **Output stability.** While `out_valid & !out_ready`, `out_data` is stable.
- **Fairness.** A requester that holds `in_valid` waits at most NREQ−1 accepted packets from others before it is granted.
- **Reset state** (asynchronous, while `rst_n` is 0):
  - `count = 0`, `wr_ptr = rd_ptr = 0`;
  - `rr_ptr = NREQ-1`, so requester 0 has first priority;
  - `grant_idx = 0`, `out_valid = 0`, `in_ready = 0`, `busy` reflects `in_valid` only.
- **Reset mid-operation.** Asserting `rst_n` mid-operation discards every FIFO packet. No output transfer completes in the reset cycle.

## Timing
- **Latency.** A packet accepted at edge N has `out_valid` high after edge N (cycle N+1) when the FIFO was empty.
- **Throughput.** One packet per cycle, sustained while `out_ready` stays high. There are no bubbles at full occupancy.
- **Fill.** With `out_ready` low, exactly DEPTH packets are accepted; after that `in_ready` is 0.
- **Resume.** The cycle `out_ready` rises with the FIFO full, one new packet can be accepted in the same cycle.

## Configuration
- **`NOC_ARB_STATS_EN` defined:**
  - `stat_grants[i]` is a 16-bit counter that saturates at 0xFFFF.
  - It increments on each input transfer from requester i.
  - It resets to 0 on `rst_n`, and synchronously when `stat_clr` is 1.
  - If `stat_clr` and an increment occur in the same cycle, `stat_clr` wins.
- **`NOC_ARB_STATS_EN` undefined:**
  - No counter flops are built.
  - `stat_grants` is driven constant 0 and `stat_clr` is ignored.
  - Arbitration behaviour is identical in both builds.

## Structure
- Shared package `noc_pkg` holds:
  - `NOC_FLIT_W = 35`;
  - `NOC_NUM_DIR = 5`;
  - enum `noc_dir_e {DIR_N, DIR_E, DIR_W, DIR_S, DIR_PE}`;
  - typedef `noc_flit_t = logic [NOC_FLIT_W-1:0]`.
- Sub-module `noc_rr_pick` is purely combinational.
  - Inputs: `req[NREQ]`, `ptr`.
  - Outputs: `gnt_onehot`, `gnt_idx`, `any`.
- The FIFO and pointer state stay in the top module.

## Test plan
- **Reset.** Reset with all `in_valid` = 1.
  - During reset: `out_valid` = 0, `in_ready` = 0.
  - After release: first grant goes to requester 0, then 1, 2, 3, 0 on consecutive cycles with `out_ready` = 1.
- **Rotation.** Only requesters 1 and 3 valid, data 35'h1_0000_0001 and 35'h3_0000_0003, `out_ready` = 1.
  - Outputs alternate 1, 3, 1, 3.
  - `grant_idx` follows one cycle after each acceptance.
- **Backpressure.** `out_ready` = 0, requester 2 streams packets A, B, C.
  - A and B are accepted, C is stalled (`in_ready[2]` = 0).
  - `out_data` = A stays stable for 5 cycles.
  - Raising `out_ready` pops A and accepts C in the same cycle.
- **Full-FIFO push and pop.** FIFO full, `out_ready` = 1 and all requesters valid for 8 cycles.
  - `count` stays at 2.
  - Output order matches the acceptance order.
  - Each requester is granted exactly twice.
- **Reset mid-stream.** Assert `rst_n` low with `count` = 2.
  - `out_valid` drops immediately (asynchronously).
  - After release, none of the old packets appear.
- **Statistics (`NOC_ARB_STATS_EN`).**
  - Accept 70000 packets from requester 0: `stat_grants[0]` = 0xFFFF.
  - Pulse `stat_clr` while an increment is pending: the counter reads 0.
  - Without the macro, `stat_grants` reads 0 throughout.
